// File: rtl/frequency_divider_pkg.sv
// Shared defaults and width helper for the clock divider.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
`timescale 1ns/1ps
package frequency_divider_pkg;

    localparam int EVEN_DIV_DEF = 4;
    localparam int ODD_DIV_DEF  = 3;

    // Counter width: clog2 of the modulus, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/freq_div_counter.sv
// Free-running modulo-MOD counter with a terminal-count flag.
// Latency: count advances every i_clk rising edge; tc is combinational from count.
// Backpressure: none, the counter never stalls.
`timescale 1ns/1ps
module freq_div_counter
    import frequency_divider_pkg::*;
#(
    parameter int MOD = 2,
    localparam int W = cnt_width(MOD)
)(
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    if (MOD < 1) begin : g_bad_mod
        $error("freq_div_counter: MOD must be >= 1");
    end

    // tc marks the last state of the cycle; MOD=1 keeps it permanently high
    assign tc = (count == LAST);

    // Advance every edge, wrapping from MOD-1 back to 0
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count <= '0;
        end else if (tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/frequency_divider.sv
// Divides i_clk by EVEN_DIV (50% duty) and by ODD_DIV; FREQ_DIV_ODD_50PCT_EN gives the odd output 50% duty.
// Latency: first even rise at edge EVEN_DIV/2 after reset release, first odd rise at edge 1.
// Backpressure: none; outputs are free-running clocks, forced low immediately by i_rst.
`timescale 1ns/1ps
module frequency_divider
    import frequency_divider_pkg::*;
#(
    parameter int EVEN_DIV = EVEN_DIV_DEF,
    parameter int ODD_DIV  = ODD_DIV_DEF
)(
    input  logic i_clk,
    input  logic i_rst,
    output logic o_freq_by_even,
    output logic o_freq_by_odd
);

    localparam int HALF_E = EVEN_DIV / 2;
    localparam int WE     = cnt_width(HALF_E);
    localparam int WO     = cnt_width(ODD_DIV);
    // pos_q is high for the first (ODD_DIV-1)/2 counter states of each period
    localparam logic [WO-1:0] ODD_HIGH = WO'((ODD_DIV - 1) / 2);

    if ((EVEN_DIV < 2) || ((EVEN_DIV % 2) != 0)) begin : g_bad_even
        $error("frequency_divider: EVEN_DIV must be even and >= 2");
    end
    if ((ODD_DIV < 3) || ((ODD_DIV % 2) == 0)) begin : g_bad_odd
        $error("frequency_divider: ODD_DIV must be odd and >= 3");
    end

    logic [WE-1:0] cnt_e;
    logic          tc_e;
    logic [WO-1:0] cnt_o;
    logic          tc_o;
    logic          pos_q;
    logic          unused_cnt;

    freq_div_counter #(.MOD(HALF_E)) u_cnt_e (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .count (cnt_e),
        .tc    (tc_e)
    );

    freq_div_counter #(.MOD(ODD_DIV)) u_cnt_o (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .count (cnt_o),
        .tc    (tc_o)
    );

    // Even path only needs the wrap flag; odd path only needs the count
    assign unused_cnt = ^{cnt_e, tc_o};

    // Toggle the even output each time the half-period counter wraps
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_freq_by_even <= 1'b0;
        end else if (tc_e) begin
            o_freq_by_even <= ~o_freq_by_even;
        end
    end

    // Rising-edge phase of the odd output, decoded from the pre-increment count
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pos_q <= 1'b0;
        end else begin
            pos_q <= (cnt_o < ODD_HIGH);
        end
    end

`ifdef FREQ_DIV_ODD_50PCT_EN
    logic neg_q;

    // Half-cycle delayed copy stretches the high phase by half an i_clk period
    always_ff @(negedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // pos_q and neg_q change on opposite clock edges, so the OR cannot glitch
    assign o_freq_by_odd = pos_q | neg_q;
`else
    assign o_freq_by_odd = pos_q;
`endif

endmodule

// File: tb/tb_frequency_divider.sv
// Scoreboard bench for frequency_divider: two instances (4/3 and 2/5) under randomized resets.
// Latency: expected values pushed per half-cycle at each clock edge, compared 1 time unit later.
// Backpressure: none.
`timescale 1ns/1ps
module tb_frequency_divider;

    localparam int E1 = 4;
    localparam int O1 = 3;
    localparam int E2 = 2;
    localparam int O2 = 5;
`ifdef FREQ_DIV_ODD_50PCT_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    bit   clk;
    logic rst;
    logic even1, odd1, even2, odd2;

    typedef struct packed {
        logic even1;
        logic odd1;
        logic even2;
        logic odd2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   h      = 0;   // half-cycles since reset release, 0 while in reset
    bit   stop   = 1'b0;

    frequency_divider #(.EVEN_DIV(E1), .ODD_DIV(O1)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_freq_by_even (even1),
        .o_freq_by_odd  (odd1)
    );

    frequency_divider #(.EVEN_DIV(E2), .ODD_DIV(O2)) dut2 (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_freq_by_even (even2),
        .o_freq_by_odd  (odd2)
    );

    always #2 clk = ~clk;

    // A square wave in half-cycle units: first high at half-cycle 'first',
    // period 'per2' half-cycles, high for 'hi' half-cycles
    function automatic logic wave(input int hh, input int first, input int per2, input int hi);
        if (hh < first) return 1'b0;
        return ((hh - first) % per2) < hi;
    endfunction

    function automatic exp_t model(input int hh);
        exp_t e;
        e.even1 = wave(hh, E1 - 1, 2 * E1, E1);
        e.odd1  = wave(hh, 1, 2 * O1, ODD50 ? O1 : O1 - 1);
        e.even2 = wave(hh, E2 - 1, 2 * E2, E2);
        e.odd2  = wave(hh, 1, 2 * O2, ODD50 ? O2 : O2 - 1);
        return e;
    endfunction

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: track phase at every edge and queue the expected outputs
    initial begin : model_proc
        forever begin
            @(posedge clk or negedge clk);
            if (rst !== 1'b1) h = 0;
            else if (clk) h = h + 1;
            else if (h > 0) h = h + 1;
            exp_q.push_back(model(h));
        end
    end

    // Monitor: sample the DUTs mid-half-cycle and compare against the queue
    initial begin : monitor_proc
        exp_t e;
        forever begin
            @(posedge clk or negedge clk);
            #1;
            if (!stop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual=0 entries required=1 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("even_div4", even1, e.even1);
                    check("odd_div3",  odd1,  e.odd1);
                    check("even_div2", even2, e.even2);
                    check("odd_div5",  odd2,  e.odd2);
                end
            end
        end
    end

    // Stimulus: randomized reset lengths, release phases, run lengths and mid-high resets
    initial begin : driver_proc
        bit found;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        for (int run = 0; run < 6; run++) begin
            if (run > 0) repeat ($urandom_range(2, 6)) @(posedge clk);
            if ($urandom_range(0, 1) == 1) @(posedge clk);
            else @(negedge clk);
            #1.5 rst = 1'b1;
            repeat ($urandom_range(20, 100)) @(posedge clk);
            found = 1'b0;
            for (int i = 0; i < 4 * E1 && !found; i++) begin
                @(posedge clk or negedge clk);
                #1.5;
                if (model(h).even1 === 1'b1) found = 1'b1;
            end
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL mid_high_wait actual=timeout required=even high at %0t", $time);
            end
            rst = 1'b0;
            #0.1;
            check("async_rst_even4", even1, 1'b0);
            check("async_rst_odd3",  odd1,  1'b0);
            check("async_rst_even2", even2, 1'b0);
            check("async_rst_odd5",  odd2,  1'b0);
        end
        repeat (4) @(posedge clk);
        stop = 1'b1;
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
